// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: round-robin arbiter sharing the Hyperbus FIFO user port, routing read returns via an in-order tag queue
module hyperbus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_DEPTH   = 4,
    parameter int WR_GUARD   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_rrq,
    input  logic [N_REQ-1:0]            req_wrq,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_adr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_dat,
    output logic [N_REQ-1:0]            req_gnt,
    output logic [N_REQ-1:0]            req_rvalid,
    output logic [DATA_WIDTH-1:0]       req_rdat,
    output logic                        rrq,
    output logic                        wrq,
    output logic [ADDR_WIDTH-1:0]       adr_o,
    output logic [DATA_WIDTH-1:0]       tx_dat_o,
    input  logic                        tx_ready,
    input  logic [DATA_WIDTH-1:0]       rx_dat_i,
    input  logic                        rx_valid,
    output logic                        rx_orphan
);
    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(RD_DEPTH) + 1;
    localparam int QW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int GW = $clog2(WR_GUARD + 1);

    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_WAIT} state_t;

    state_t          r_state;
    logic [GW-1:0]   r_guard;
    logic [TW-1:0]   r_ptr;
    logic [CW-1:0]   r_rd_count;
    logic [TW-1:0]   r_tags [RD_DEPTH];
    logic [QW-1:0]   r_head;
    logic [QW-1:0]   r_tail;

    logic [N_REQ-1:0] w_req;
    logic [TW-1:0]    w_cand;
    logic [TW-1:0]    w_win;
    logic             w_found;
    logic             w_pop;
    logic             w_idle;
    logic             w_rd;
    logic             w_wr;
    logic [TW-1:0]    w_head_tag;

    // The port granted last cycle still shows its request while it sees req_gnt
    assign w_req      = (req_rrq | req_wrq) & ~req_gnt;
    assign w_pop      = rx_valid && (r_rd_count != '0);
    assign w_idle     = (r_state == S_IDLE);
    assign w_head_tag = r_tags[r_head];

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = TW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // An ineligible winner blocks the cycle outright so writers cannot be starved
    assign w_rd = w_found && req_rrq[w_win] && w_idle
                  && ((r_rd_count < CW'(RD_DEPTH)) || w_pop);
    assign w_wr = w_found && !req_rrq[w_win] && w_idle
                  && (r_rd_count == '0) && tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_guard    <= '0;
            r_ptr      <= TW'(N_REQ - 1);
            r_rd_count <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int i = 0; i < RD_DEPTH; i++) r_tags[i] <= '0;
            req_gnt    <= '0;
            req_rvalid <= '0;
            req_rdat   <= '0;
            rrq        <= 1'b0;
            wrq        <= 1'b0;
            adr_o      <= '0;
            tx_dat_o   <= '0;
            rx_orphan  <= 1'b0;
        end else begin
            req_gnt    <= (w_rd || w_wr) ? (N_REQ'(1) << w_win) : '0;
            rrq        <= w_rd;
            wrq        <= w_wr;
            rx_orphan  <= rx_valid && (r_rd_count == '0);
            req_rvalid <= w_pop ? (N_REQ'(1) << w_head_tag) : '0;
            if (w_pop) begin
                req_rdat <= rx_dat_i;
                r_head   <= (r_head == QW'(RD_DEPTH - 1)) ? '0 : r_head + QW'(1);
            end
            if (w_rd || w_wr) begin
                adr_o <= req_adr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                r_ptr <= w_win;
            end
            if (w_wr) tx_dat_o <= req_dat[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
            // On a full queue with a pop, head is read before the slot is reused
            if (w_rd) begin
                r_tags[r_tail] <= w_win;
                r_tail         <= (r_tail == QW'(RD_DEPTH - 1)) ? '0 : r_tail + QW'(1);
            end
            if (w_rd && !w_pop) r_rd_count <= r_rd_count + CW'(1);
            else if (!w_rd && w_pop) r_rd_count <= r_rd_count - CW'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        r_state <= S_GUARD;
                        r_guard <= GW'(WR_GUARD - 1);
                    end
                end
                S_GUARD: begin
                    if (r_guard == '0) r_state <= S_WAIT;
                    else r_guard <= r_guard - GW'(1);
                end
                S_WAIT: begin
                    if (tx_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb_hyperbus_arbiter: directed and randomized stimulus checked cycle by cycle against a queue-based arbiter model
module tb_hyperbus_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RD = 4;
    localparam int G  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_rrq = '0;
    logic [N-1:0]    req_wrq = '0;
    logic [N*AW-1:0] req_adr = '0;
    logic [N*DW-1:0] req_dat = '0;
    logic [N-1:0]    req_gnt;
    logic [N-1:0]    req_rvalid;
    logic [DW-1:0]   req_rdat;
    logic            rrq;
    logic            wrq;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   tx_dat_o;
    logic            tx_ready = 1'b1;
    logic [DW-1:0]   rx_dat_i = '0;
    logic            rx_valid = 1'b0;
    logic            rx_orphan;

    hyperbus_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_DEPTH(RD), .WR_GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_rrq(req_rrq), .req_wrq(req_wrq), .req_adr(req_adr),
        .req_dat(req_dat), .req_gnt(req_gnt), .req_rvalid(req_rvalid), .req_rdat(req_rdat),
        .rrq(rrq), .wrq(wrq), .adr_o(adr_o), .tx_dat_o(tx_dat_o), .tx_ready(tx_ready),
        .rx_dat_i(rx_dat_i), .rx_valid(rx_valid), .rx_orphan(rx_orphan)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int            m_ptr;
    int            m_last;
    int            m_q[$];
    bit            m_writing;
    int            m_wr_cyc;
    int            cyc = 0;
    logic [N-1:0]  e_gnt, e_rvalid, prev_gnt;
    logic          e_rrq, e_wrq, e_orph;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_txd, e_rdat;
    bit            e_gnt_rd, prev_rd;

    task automatic model_reset();
        m_ptr = N - 1;
        m_last = -1;
        m_q.delete();
        m_writing = 0;
        e_gnt = '0; e_rvalid = '0; e_rrq = 0; e_wrq = 0; e_orph = 0;
        e_adr = '0; e_txd = '0; e_rdat = '0; e_gnt_rd = 0;
    endtask

    task automatic model_step();
        bit pop, blocked, rd_ok, wr_ok;
        int win;
        logic [N-1:0] mreq;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop = rx_valid && m_q.size() > 0;
        e_orph = rx_valid && m_q.size() == 0;
        blocked = m_writing;
        if (m_writing && cyc - m_wr_cyc >= G + 1 && tx_ready) m_writing = 0;
        mreq = req_rrq | req_wrq;
        if (m_last >= 0) mreq[m_last] = 1'b0;
        win = -1;
        for (int k = 1; k <= N; k++)
            if (win < 0 && mreq[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        rd_ok = win >= 0 && req_rrq[win] && !blocked && (m_q.size() < RD || pop);
        wr_ok = win >= 0 && !req_rrq[win] && !blocked && m_q.size() == 0 && tx_ready;
        e_rvalid = '0;
        if (pop) begin
            e_rvalid[m_q[0]] = 1'b1;
            e_rdat = rx_dat_i;
            void'(m_q.pop_front());
        end
        e_gnt = '0; e_rrq = rd_ok; e_wrq = wr_ok; m_last = -1;
        if (rd_ok || wr_ok) begin
            e_gnt[win] = 1'b1;
            e_adr = req_adr[win*AW +: AW];
            m_ptr = win;
            m_last = win;
            e_gnt_rd = rd_ok;
            if (rd_ok) m_q.push_back(win);
            if (wr_ok) begin
                e_txd = req_dat[win*DW +: DW];
                m_writing = 1;
                m_wr_cyc = cyc;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt", req_gnt, e_gnt);
        chk("rrq", rrq, e_rrq);
        chk("wrq", wrq, e_wrq);
        chk("adr", adr_o, e_adr);
        chk("txdat", tx_dat_o, e_txd);
        chk("rvalid", req_rvalid, e_rvalid);
        chk("rdat", req_rdat, e_rdat);
        chk("orphan", rx_orphan, e_orph);
        // requesters drop a request once the cycle showing its grant has passed
        for (int i = 0; i < N; i++)
            if (prev_gnt[i]) begin
                if (prev_rd) req_rrq[i] = 1'b0;
                else req_wrq[i] = 1'b0;
            end
        prev_gnt = e_gnt;
        prev_rd = e_gnt_rd;
    endtask

    task automatic raise(input int i, input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_adr[i*AW +: AW] = a;
        req_dat[i*DW +: DW] = d;
        if (kind != 1) req_rrq[i] = 1'b1;
        if (kind != 0) req_wrq[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_rrq = '0;
        req_wrq = '0;
        rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && m_q.size() > 0; i++) begin
            rx_valid = 1'b1;
            rx_dat_i = $urandom;
            tick();
        end
        rx_valid = 1'b0;
        chk("drain", m_q.size(), 0);
    endtask

    initial begin
        prev_gnt = '0;
        prev_rd = 0;
        model_reset();
        do_reset();
        tick();
        chk("rst_gnt", req_gnt, 0);
        chk("rst_adr", adr_o, 0);

        // single read from port 2
        raise(2, 0, 32'h100, 0);
        tick();
        chk("sr_gnt", req_gnt, 4'b0100);
        chk("sr_rrq", rrq, 1);
        chk("sr_adr", adr_o, 32'h100);
        rx_valid = 1'b1;
        rx_dat_i = 32'hDEADBEEF;
        tick();
        chk("sr_rvalid", req_rvalid, 4'b0100);
        chk("sr_rdat", req_rdat, 32'hDEADBEEF);
        rx_valid = 1'b0;
        tick();

        // round robin from reset, stall at full, push/pop at full
        do_reset();
        for (int i = 0; i < N; i++) raise(i, 0, 32'h1000 + i, 0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("rr_gnt", req_gnt, 1 << k);
        end
        raise(0, 0, 32'h2000, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("rr_stall", req_gnt, 0);
        rx_valid = 1'b1;
        rx_dat_i = 32'hA0;
        tick();
        chk("rr_full_gnt", req_gnt, 4'b0001);
        drain();
        tick();

        // write gated by outstanding reads and tx_ready
        do_reset();
        raise(0, 0, 32'h10, 0);
        tick(); tick();
        raise(0, 0, 32'h14, 0);
        tick(); tick();
        tx_ready = 1'b0;
        raise(1, 1, 32'h20, 32'h12345678);
        for (int k = 0; k < 3; k++) tick();
        drain();
        for (int k = 0; k < 3; k++) tick();
        chk("wg_nowrq", wrq, 0);
        tx_ready = 1'b1;
        for (int k = 0; k < 10 && !wrq; k++) tick();
        chk("wg_wrq", wrq, 1);
        chk("wg_txd", tx_dat_o, 32'h12345678);
        raise(2, 0, 32'h30, 0);
        tx_ready = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("wg_blocked", req_gnt, 0);
        tx_ready = 1'b1;
        tick(); tick();
        chk("wg_resume", req_gnt, 4'b0100);
        drain();

        // both bits on port 3: read first, write later
        do_reset();
        raise(3, 2, 32'h40, 32'h55AA);
        tick();
        chk("both_rd", rrq, 1);
        for (int k = 0; k < 4; k++) tick();
        drain();
        for (int k = 0; k < 4 && !wrq; k++) tick();
        chk("both_wr", wrq, 1);
        for (int k = 0; k < 12; k++) tick();

        // orphan while idle
        rx_valid = 1'b1;
        rx_dat_i = 32'hBAD;
        tick();
        chk("orph", rx_orphan, 1);
        chk("orph_rv", req_rvalid, 0);
        rx_valid = 1'b0;
        tick();

        // reset with three reads outstanding
        for (int i = 1; i < N; i++) raise(i, 0, 32'h50 + i, 0);
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        chk("mr_rrq", rrq, 0);
        rst_n = 1'b1;
        rx_valid = 1'b1;
        tick();
        chk("mr_orph", rx_orphan, 1);
        rx_valid = 1'b0;
        req_rrq = '0;
        raise(0, 0, 32'h60, 0);
        raise(2, 0, 32'h62, 0);
        tick();
        chk("mr_first", req_gnt, 4'b0001);
        for (int k = 0; k < 4; k++) tick();
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!(req_rrq[i] | req_wrq[i]) && $urandom_range(0, 3) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    raise(i, r < 6 ? 0 : (r < 8 ? 1 : 2), $urandom, $urandom);
                end
            rx_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rx_dat_i = $urandom;
            tx_ready = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 499) != 0;
            tick();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
